regwrite_port_arbiter: RTL
==========================

Name: regwrite_port_arbiter

Overview: Shares the register bank's single write port among N_REQ write-back requesters, e.g. R-type ALU, load, link (jal) and stack-pointer update. Arbitrates round-robin, latches the winner's 3-bit destination select (drives the RegDst mux select) and write-data select (drives the MemToReg mux select), then issues a one-cycle RegWrite. Sits between the multicycle control unit and the register-bank write path.

Parameters:
N_REQ, 4, number of requesters, legal range 2..8; index width IDX_W = clog2(N_REQ), internal.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  N_REQ  write request per requester; held high until its gnt
req_regdst  input  3*N_REQ  packed RegDst code per requester; slice i = bits [3i+2:3i]
req_wdsel  input  3*N_REQ  packed MemToReg code per requester; slice i = bits [3i+2:3i]
hold  input  1  control-unit stall; blocks new arbitration and SETUP→WRITE
regdst  output  3  select to the RegDst mux
memtoreg  output  3  select to the write-data mux
reg_write  output  1  register-bank write enable
gnt  output  N_REQ  one-hot, one-cycle grant pulse
busy  output  1  high when state ≠ IDLE
err  output  1  one-cycle pulse when an illegal RegDst code is dropped

Behaviour:
- Reset (reset=0, async): state IDLE, ptr 0, cur 0, regdst 000, memtoreg 000, reg_write 0, gnt 0, busy 0, err 0. A write in flight is discarded: no reg_write and no gnt.
- All outputs are registered. regdst and memtoreg hold their last latched values in IDLE.
- States: IDLE, SETUP, WRITE.
- Arbitration: pick the first set req[i], scanning i = ptr, ptr+1, … mod N_REQ. Latch cur, regdst ← slice cur of req_regdst, memtoreg ← slice cur of req_wdsel.
- IDLE: if hold=0 and req≠0, arbitrate and go to SETUP. Otherwise stay.
- SETUP: reg_write=0 so the mux selects settle for one full cycle.
  - If req[cur]=0 (requester withdrew): go to IDLE. No gnt, no write, ptr unchanged.
  - Else if hold=1: stay in SETUP.
  - Else: go to WRITE.
- WRITE: lasts exactly one cycle.
  - Outputs: reg_write=1 and gnt[cur]=1.
  - ptr ← (cur+1) mod N_REQ.
  - hold is ignored in this state; the write commits.
  - Next state: if hold=0 and (req with bit cur masked) ≠ 0, arbitrate from the new ptr and go directly to SETUP. Otherwise go to IDLE.
  - Sustained throughput: one write per 2 cycles.
- Latency: req rises at edge k in IDLE → SETUP at k+1 → reg_write/gnt high during cycle k+2.
- Legal regdst codes are 000–101. For 110 or 111, WRITE holds reg_write=0 and pulses err=1; gnt[cur] still pulses so the requester releases.
- A requester must drop req the cycle after its gnt. If req[cur] is still high in the following IDLE/arbitration, it is treated as a new request.
- gnt is always one-hot or zero. reg_write=1 implies exactly one gnt bit set.
- A new req arriving while busy waits. Arbitration only occurs in IDLE or at the end of WRITE.

Test Plan:
- Single request: N_REQ=4, req=0001, regdst slice0=001, wdsel slice0=000 → regdst=001 from cycle 2, reg_write=1 and gnt=0001 in cycle 3 only, then busy=0.
- Round-robin: req=1111 held, each requester dropping one cycle after its grant; all regdst codes 011 → gnt order 0001, 0010, 0100, 1000, one grant every 2 cycles, ptr wraps to 0.
- Hold: hold=1 while in SETUP for 3 cycles → no reg_write and regdst stable. hold=0 → WRITE on the next cycle. hold=1 asserted during WRITE → write still commits.
- Withdrawal: req[2] drops during SETUP → no gnt, no reg_write, return to IDLE. Next request req=0010 is granted normally.
- Illegal code: req[1] with regdst 111 → err=1, gnt=0010, reg_write=0 in the same cycle.
- Async reset: reset low mid-SETUP and released → all outputs 0, state IDLE, ptr 0, and no write occurs for that request.

Source files
------------

// File: rtl/regwrite_port_arbiter.sv
// Round-robin arbiter sharing the register-bank write port among N_REQ write-back sources.
// Each grant runs IDLE -> SETUP (mux selects settle) -> WRITE (one-cycle RegWrite + grant).
module regwrite_port_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] req_regdst,
  input  logic [3*N_REQ-1:0] req_wdsel,
  input  logic               hold,
  output logic [2:0]         regdst,
  output logic [2:0]         memtoreg,
  output logic               reg_write,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, cur_q, cur_d;
  logic [2:0]         regdst_q, regdst_d, wdsel_q, wdsel_d;
  logic               rw_q, rw_d, err_q, err_d, busy_q, busy_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;

  logic [N_REQ-1:0]   cur_oh, arb_req;
  logic [IDX_W-1:0]   arb_ptr, pick_idx;
  logic [IDX_W:0]     pick;
  logic               arb_take;

  // Returns {found, index} of the first set bit scanning from p upward, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IDX_W-1:0] p);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      idx = (int'(p) + j) % N_REQ;
      if (r[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] c);
    return (c == IDX_W'(N_REQ - 1)) ? '0 : c + 1'b1;
  endfunction

  function automatic logic legal_dst(input logic [2:0] code);
    return code <= 3'd5;
  endfunction

  assign cur_oh   = N_REQ'(1) << cur_q;
  // At the end of WRITE the granted requester still holds req, so it is masked out.
  assign arb_ptr  = (state_q == WRITE) ? next_idx(cur_q) : ptr_q;
  assign arb_req  = (state_q == WRITE) ? (req & ~cur_oh) : req;
  assign pick     = rr_pick(arb_req, arb_ptr);
  assign pick_idx = pick[IDX_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    regdst_d = regdst_q;
    wdsel_d  = wdsel_q;
    arb_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hold && pick[IDX_W]) begin
          state_d  = SETUP;
          arb_take = 1'b1;
        end
      end
      SETUP: begin
        if (!req[cur_q])  state_d = IDLE;
        else if (!hold)   state_d = WRITE;
      end
      WRITE: begin
        ptr_d = arb_ptr;
        if (!hold && pick[IDX_W]) begin
          state_d  = SETUP;
          arb_take = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (arb_take) begin
      cur_d    = pick_idx;
      regdst_d = req_regdst[3*pick_idx +: 3];
      wdsel_d  = req_wdsel[3*pick_idx +: 3];
    end
  end

  always_comb begin
    rw_d   = 1'b0;
    err_d  = 1'b0;
    gnt_d  = '0;
    busy_d = (state_d != IDLE);
    if (state_q == SETUP && state_d == WRITE) begin
      gnt_d = cur_oh;
      rw_d  = legal_dst(regdst_q);
      err_d = !legal_dst(regdst_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q    <= '0;
      cur_q    <= '0;
      regdst_q <= '0;
      wdsel_q  <= '0;
      rw_q     <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      cur_q    <= cur_d;
      regdst_q <= regdst_d;
      wdsel_q  <= wdsel_d;
      rw_q     <= rw_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      gnt_q    <= gnt_d;
    end
  end

  assign regdst    = regdst_q;
  assign memtoreg  = wdsel_q;
  assign reg_write = rw_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
